// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: assembles UART host bytes into SDRAM read/write
// commands and answers with 'K', read data bytes, or '?'.
//
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_rx_rdy, i_rx_data        RX FIFO non-empty flag and head byte
//   o_rx_req                   one-cycle RX FIFO pop
//   i_tx_rdy                   TX FIFO not full
//   o_tx_data, o_tx_req        TX byte and one-cycle TX FIFO push
//   o_mem_req, i_mem_ready     memory request valid/ready handshake
//   o_mem_we, o_mem_addr       request direction and address
//   o_mem_wdata                request write data
//   i_mem_rvalid, i_mem_rdata  read data strobe and value
module uart_cmd_bridge #(
    parameter int AddrWidth     = 24,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 5_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_rdy,
    input  logic [7:0]           i_rx_data,
    output logic                 o_rx_req,
    input  logic                 i_tx_rdy,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_req,
    output logic                 o_mem_req,
    input  logic                 i_mem_ready,
    output logic                 o_mem_we,
    output logic [AddrWidth-1:0] o_mem_addr,
    output logic [DataWidth-1:0] o_mem_wdata,
    input  logic                 i_mem_rvalid,
    input  logic [DataWidth-1:0] i_mem_rdata
);

    localparam int AB = (AddrWidth + 7) / 8;
    localparam int DB = (DataWidth + 7) / 8;
    localparam int SW = DB * 8;

    localparam logic [7:0]    CMD_W    = 8'h57;
    localparam logic [7:0]    CMD_R    = 8'h52;
    localparam logic [SW-1:0] SH_ACK   = SW'(8'h4B) << (SW - 8);
    localparam logic [SW-1:0] SH_NAK   = SW'(8'h3F) << (SW - 8);
    localparam logic [7:0]    ADDR_END = 8'(AB - 1);
    localparam logic [7:0]    DATA_END = 8'(DB - 1);
    localparam logic [7:0]    SEND_CNT = 8'(DB);
    localparam logic [31:0]   TMO_LAST = 32'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_SEND
    } state_e;

    state_e               state_q;
    logic                 rx_hold_q;
    logic                 tx_hold_q;
    logic [7:0]           cnt_q;
    logic [31:0]          tmo_q;
    logic                 we_q;
    logic                 mem_req_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [SW-1:0]        sh_q;

    logic                 rcv;
    logic                 getting;
    logic                 tmo_hit;
    logic [AddrWidth-1:0] addr_d;
    logic [DataWidth-1:0] wdata_d;

    assign getting = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
    assign rcv     = (state_q == S_IDLE) || getting;

    // The FIFO flag lags a pop by one cycle, so a pop is never
    // issued in the cycle right after another one.  rx_hold_q is also
    // set by reset so no pop appears in the first cycle out of reset.
    assign o_rx_req = rcv && i_rx_rdy && !rx_hold_q;
    assign o_tx_req = (state_q == S_SEND) && i_tx_rdy && !tx_hold_q;

    assign tmo_hit = getting && !o_rx_req && (tmo_q == TMO_LAST);

    // Shift in one byte MSB first; the cast drops bits above the width.
    assign addr_d  = AddrWidth'({addr_q, i_rx_data});
    assign wdata_d = DataWidth'({wdata_q, i_rx_data});

    assign o_tx_data   = sh_q[SW-1 -: 8];
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            rx_hold_q <= 1'b1;
            tx_hold_q <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sh_q      <= '0;
        end else begin
            rx_hold_q <= o_rx_req;
            tx_hold_q <= o_tx_req;
            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (o_rx_req) begin
                        if (i_rx_data == CMD_W || i_rx_data == CMD_R) begin
                            we_q    <= (i_rx_data == CMD_W);
                            cnt_q   <= '0;
                            state_q <= S_GET_ADDR;
                        end else begin
                            sh_q    <= SH_NAK;
                            cnt_q   <= 8'd1;
                            state_q <= S_SEND;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (o_rx_req) begin
                        tmo_q  <= '0;
                        addr_q <= addr_d;
                        if (cnt_q == ADDR_END) begin
                            cnt_q <= '0;
                            if (we_q) begin
                                state_q <= S_GET_DATA;
                            end else begin
                                mem_req_q <= 1'b1;
                                state_q   <= S_MEM_REQ;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end else if (tmo_hit) begin
                        tmo_q   <= '0;
                        sh_q    <= SH_NAK;
                        cnt_q   <= 8'd1;
                        state_q <= S_SEND;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_GET_DATA: begin
                    if (o_rx_req) begin
                        tmo_q   <= '0;
                        wdata_q <= wdata_d;
                        if (cnt_q == DATA_END) begin
                            cnt_q     <= '0;
                            mem_req_q <= 1'b1;
                            state_q   <= S_MEM_REQ;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end else if (tmo_hit) begin
                        tmo_q   <= '0;
                        sh_q    <= SH_NAK;
                        cnt_q   <= 8'd1;
                        state_q <= S_SEND;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_q && i_mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            sh_q    <= SH_ACK;
                            cnt_q   <= 8'd1;
                            state_q <= S_SEND;
                        end else begin
                            state_q <= S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (i_mem_rvalid) begin
                        sh_q    <= SW'(i_mem_rdata);
                        cnt_q   <= SEND_CNT;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (o_tx_req) begin
                        sh_q  <= sh_q << 8;
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: RX FIFO model feeds bytes,
// expected TX bytes and memory requests are queued and compared.
module tb_uart_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx_rdy = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_rx_req;
    logic        i_tx_rdy = 1'b1;
    logic [7:0]  o_tx_data;
    logic        o_tx_req;
    logic        o_mem_req;
    logic        i_mem_ready = 1'b0;
    logic        o_mem_we;
    logic [23:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        i_mem_rvalid = 1'b0;
    logic [15:0] i_mem_rdata = 16'h0;

    uart_cmd_bridge #(
        .AddrWidth    (24),
        .DataWidth    (16),
        .TimeoutCycles(100)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_rdy    (i_rx_rdy),
        .i_rx_data   (i_rx_data),
        .o_rx_req    (o_rx_req),
        .i_tx_rdy    (i_tx_rdy),
        .o_tx_data   (o_tx_data),
        .o_tx_req    (o_tx_req),
        .o_mem_req   (o_mem_req),
        .i_mem_ready (i_mem_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  rxq[$];
    logic [7:0]  exp_tx[$];
    logic [40:0] exp_mem[$];

    int cyc = 0;
    bit pop_pend = 0;
    int pop_cyc = 0, tx_cyc = 0, acc_cyc = 0, rise_cyc = 0;
    int tx_cnt = 0, rises = 0, bp_viol = 0, adj_viol = 0;
    bit tx_prev = 0, req_prev = 0;
    logic [40:0] held = '0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_pend) begin
            void'(rxq.pop_front());
            pop_pend = 0;
        end
        i_rx_rdy  = (rxq.size() != 0);
        i_rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_prev  = 0;
            req_prev = 0;
        end else begin
            if (o_rx_req) begin
                pop_pend = 1;
                pop_cyc  = cyc;
            end
            if (o_tx_req) begin
                if (!i_tx_rdy) bp_viol++;
                if (tx_prev) adj_viol++;
                if (exp_tx.size() == 0)
                    check("tx_extra", exp_tx.size(), 1);
                else
                    check("tx_byte", o_tx_data, exp_tx.pop_front());
                tx_cnt++;
                tx_cyc = cyc;
            end
            tx_prev = o_tx_req;
            if (o_mem_req && !req_prev) begin
                rises++;
                rise_cyc = cyc;
            end
            if (o_mem_req && req_prev)
                check("mem_stable", {o_mem_we, o_mem_addr, o_mem_wdata}, held);
            held     = {o_mem_we, o_mem_addr, o_mem_wdata};
            req_prev = o_mem_req;
            if (o_mem_req && i_mem_ready) begin
                acc_cyc = cyc;
                if (exp_mem.size() == 0) begin
                    check("mem_extra", exp_mem.size(), 1);
                end else begin
                    logic [40:0] e;
                    e = exp_mem.pop_front();
                    check("mem_we", o_mem_we, e[40]);
                    check("mem_addr", o_mem_addr, e[39:16]);
                    if (e[40]) check("mem_wdata", o_mem_wdata, e[15:0]);
                end
            end
        end
    end

    task automatic rx(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic mem_serve(input logic we, input logic [23:0] a,
                             input logic [15:0] d, input int rdy_dly,
                             input int rv_dly);
        exp_mem.push_back({we, a, we ? d : 16'h0});
        if (we) exp_tx.push_back(8'h4B);
        for (int n = 0; n < 500 && !o_mem_req; n++) @(negedge clk);
        check("mem_seen", o_mem_req, 1);
        if (!o_mem_req) return;
        @(posedge clk);
        repeat (rdy_dly) @(posedge clk);
        #1 i_mem_ready = 1'b1;
        @(posedge clk);
        #1 i_mem_ready = 1'b0;
        if (!we) begin
            repeat (rv_dly - 1) @(posedge clk);
            #1;
            exp_tx.push_back(d[15:8]);
            exp_tx.push_back(d[7:0]);
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = d;
            @(posedge clk);
            #1 i_mem_rvalid = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        for (int n = 0; n < bound &&
             (exp_tx.size() != 0 || exp_mem.size() != 0 || rxq.size() != 0);
             n++)
            @(negedge clk);
        check("drain", exp_tx.size() + exp_mem.size() + rxq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_rx"}, o_rx_req, 0);
        check({tag, "_tx"}, {o_tx_req, o_tx_data}, 0);
        check({tag, "_req"}, {o_mem_req, o_mem_we}, 0);
        check({tag, "_fld"}, {o_mem_addr, o_mem_wdata}, 0);
    endtask

    initial begin
        int t0;
        int r0;
        rx(8'h00);
        repeat (3) @(posedge clk);
        #1 outs_zero("rst");
        rxq.delete();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // write
        rx(8'h57); rx(8'h01); rx(8'h23); rx(8'h45); rx(8'hBE); rx(8'hEF);
        mem_serve(1'b1, 24'h012345, 16'hBEEF, 3, 0);
        drain(200);
        check("wr_lat", rise_cyc - pop_cyc, 1);
        check("ack_lat", (tx_cyc - acc_cyc) <= 2, 1);

        // read, then stray rvalid in idle
        rx(8'h52); rx(8'h00); rx(8'h00); rx(8'h10);
        mem_serve(1'b0, 24'h000010, 16'h1234, 0, 5);
        drain(200);
        t0 = tx_cnt;
        @(posedge clk);
        #1 i_mem_rvalid = 1'b1; i_mem_rdata = 16'hFFFF;
        @(posedge clk);
        #1 i_mem_rvalid = 1'b0;
        repeat (10) @(posedge clk);
        check("stray_rv", tx_cnt, t0);

        // unknown then read back to back
        rx(8'h41); exp_tx.push_back(8'h3F);
        rx(8'h52); rx(8'h00); rx(8'h00); rx(8'h01);
        mem_serve(1'b0, 24'h000001, 16'hC3A5, 1, 2);
        drain(200);

        // timeout mid-command
        r0 = rises;
        rx(8'h57); rx(8'h01); exp_tx.push_back(8'h3F);
        drain(400);
        check("tmo_nomem", rises, r0);
        check("tmo_lat", (tx_cyc - pop_cyc) >= 100 && (tx_cyc - pop_cyc) <= 102, 1);
        rx(8'h52); rx(8'h00); rx(8'h00); rx(8'h02);
        mem_serve(1'b0, 24'h000002, 16'h0F0E, 0, 3);
        drain(200);

        // tx backpressure
        #1 i_tx_rdy = 1'b0;
        rx(8'h52); rx(8'h00); rx(8'h00); rx(8'h04);
        mem_serve(1'b0, 24'h000004, 16'hA55A, 0, 3);
        t0 = tx_cnt;
        repeat (20) @(posedge clk);
        check("bp_hold", tx_cnt, t0);
        #1 i_tx_rdy = 1'b1;
        drain(200);
        check("bp_viol", bp_viol, 0);
        check("adj_push", adj_viol, 0);

        // reset mid-command
        rx(8'h57); rx(8'h01); rx(8'h23);
        for (int n = 0; n < 100 && rxq.size() != 0; n++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 outs_zero("mid");
        rst_n = 1'b1;
        rx(8'h52); rx(8'h00); rx(8'h00); rx(8'h03);
        mem_serve(1'b0, 24'h000003, 16'h5678, 2, 4);
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
